mux4_rr_arbiter: RTL

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter_pkg.sv | 28 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 41 ++++
 rtl/mux4_rr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the 4-input round-robin mux arbiter:
//   - arb_state_t    : arbiter FSM states (IDLE, GRANT, GAP)
//   - NUM_REQ        : number of requesters / mux data inputs
//   - IDX_W          : width of a requester index (mux select width)
//   - idx_to_onehot  : index -> one-hot requester mask helper
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // One-hot mask with only bit 'idx' set.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] mask;
        mask      = {NUM_REQ{1'b0}};
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Purely combinational rotating-priority search over four requesters.
// The search order is ptr+1, ptr+2, ptr+3, ptr (mod 4), so the requester at
// 'ptr' (the most recent owner) always has the lowest priority.
// Ports:
//   req [3:0] : request vector
//   ptr [1:0] : index of the lowest-priority requester
//   idx [1:0] : first asserted requester in search order (ptr when none)
//   any       : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand_s;

    // Walk the four offsets from ptr+1 and keep the first asserted request.
    always_comb begin
        idx    = ptr;
        any    = 1'b0;
        cand_s = ptr;
        for (int i = 1; i <= 4; i++) begin
            // Offset 4 wraps to ptr itself in the 2-bit sum.
            cand_s = IDX_W'(ptr + IDX_W'(i));
            if (!any && req[cand_s]) begin
                idx = cand_s;
                any = 1'b1;
            end else begin
                idx = idx;
                any = any;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter driving the select and enable of a 4:1 transmission-
// gate mux. A granted owner keeps the mux until it drops its request, or
// until it has held MAXHOLD cycles while someone else is waiting. Every
// hand-over passes through a one-cycle GAP with gnt/en low so that two
// transmission gates are never on at the same time (break-before-make).
// Parameters:
//   MAXHOLD   : maximum consecutive grant cycles under contention (2..255)
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   req [3:0] : level requests, req[i] from mux input i (a/b/c/d = 0..3)
//   gnt [3:0] : one-hot grant or all zero
//   s1, s0    : mux select, {s1,s0} = owner index (held outside GRANT)
//   en        : mux output carries the owner's data
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s1,
    output logic               s0,
    output logic               en
);

    localparam int unsigned       CNT_W   = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAXHOLD - 1);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [IDX_W-1:0]    sel_r;
    logic [IDX_W-1:0]    sel_nxt_s;
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    ptr_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [NUM_REQ-1:0]  gnt_nxt_s;
    logic                en_r;
    logic                en_nxt_s;

    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;
    logic [NUM_REQ-1:0]  others_s;
    logic                release_s;
    logic                preempt_s;
    logic                leave_grant_s;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // While in GRANT, sel_r is the owner index.
    assign others_s      = req & ~idx_to_onehot(sel_r);
    assign release_s     = ~req[sel_r];
    assign preempt_s     = (cnt_r == CNT_MAX) && (others_s != {NUM_REQ{1'b0}});
    // Release and pre-emption in the same cycle collapse into one exit.
    assign leave_grant_s = release_s | preempt_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (leave_grant_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            GAP: begin
                // Only requests present at the GAP-exit edge matter.
                if (pick_any_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output and datapath next values, keyed on the state being entered.
    always_comb begin
        gnt_nxt_s = gnt_r;
        en_nxt_s  = en_r;
        sel_nxt_s = sel_r;
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        case (state_nxt_s)
            GRANT: begin
                if (state_r != GRANT) begin
                    // Fresh pick: the select moves only here.
                    sel_nxt_s = pick_idx_s;
                    gnt_nxt_s = idx_to_onehot(pick_idx_s);
                    en_nxt_s  = 1'b1;
                    cnt_nxt_s = {CNT_W{1'b0}};
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            GAP: begin
                // Last owner becomes lowest priority for the next pick.
                gnt_nxt_s = {NUM_REQ{1'b0}};
                en_nxt_s  = 1'b0;
                ptr_nxt_s = sel_r;
            end
            IDLE: begin
                gnt_nxt_s = {NUM_REQ{1'b0}};
                en_nxt_s  = 1'b0;
            end
            default: begin
                gnt_nxt_s = {NUM_REQ{1'b0}};
                en_nxt_s  = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; ptr resets to 3 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r <= {NUM_REQ{1'b0}};
            en_r  <= 1'b0;
            sel_r <= {IDX_W{1'b0}};
            ptr_r <= 2'd3;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            gnt_r <= gnt_nxt_s;
            en_r  <= en_nxt_s;
            sel_r <= sel_nxt_s;
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign gnt = gnt_r;
    assign s1  = sel_r[1];
    assign s0  = sel_r[0];
    assign en  = en_r;

endmodule
